// File: rtl/sum_block_averager.sv
// Block averager: sums non-overlapping blocks of 2^M samples, queues each truncated
// mean in a small FIFO and hands results downstream over a valid/ready handshake.
module sum_block_averager #(
  parameter int DW    = 8,
  parameter int M     = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] inp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] outp,
  output logic          overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [M-1:0]  CNT_LAST = '1;
  localparam logic [M-1:0]  CNT_ONE  = M'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   PTR_MSB  = {1'b1, {AW{1'b0}}};

  logic [DW+M-1:0] acc_reg;
  logic [M-1:0]    cnt_reg;
  logic [DW+M-1:0] sum;
  logic [DW-1:0]   result;
  logic            last;

  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic [DW-1:0]   mem_reg [DEPTH];
  logic            overrun_reg;
  logic            full;
  logic            empty;
  logic            pop;
  logic            wr_en;

  // Accumulator is wide enough for 2^M full-scale samples, so the sum never wraps.
  assign sum    = acc_reg + {{M{1'b0}}, inp};
  assign result = sum[DW+M-1:M];
  assign last   = in_valid && (cnt_reg == CNT_LAST);

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = ((wr_ptr_reg ^ rd_ptr_reg) == PTR_MSB);
  assign pop    = !empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_en  = last && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (in_valid) begin
      if (last) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= sum;
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (last && full && !pop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= result;
    end
  end

  assign out_valid = !empty;
  assign outp      = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_sum_block_averager.sv
// Directed bench for sum_block_averager with a queue-based reference of the result FIFO.
module tb_sum_block_averager;

  localparam int DW    = 8;
  localparam int M     = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] inp;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] outp;
  logic          overrun;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: block accumulator, sample count, expected FIFO contents, sticky flag.
  int         m_acc = 0;
  int         m_cnt = 0;
  logic [7:0] m_q[$];
  logic       m_ovr = 1'b0;

  sum_block_averager #(.DW(DW), .M(M), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .inp      (inp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .outp     (outp),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: update the reference for this edge, then compare outputs 1 time unit later.
  task automatic tick();
    logic [7:0] res;
    logic       do_push;
    logic       do_pop;
    @(posedge clk);
    do_push = 1'b0;
    res     = '0;
    if (!rst_n) begin
      m_acc = 0;
      m_cnt = 0;
      m_q.delete();
      m_ovr = 1'b0;
    end else begin
      do_pop = (m_q.size() != 0) && out_ready;
      if (in_valid) begin
        if (m_cnt < (1 << M) - 1) begin
          m_acc = m_acc + int'(inp);
          m_cnt = m_cnt + 1;
        end else begin
          res     = 8'((m_acc + int'(inp)) >> M);
          m_acc   = 0;
          m_cnt   = 0;
          do_push = 1'b1;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(res);
        else m_ovr = 1'b1;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("outp", 32'(outp), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic send(input logic v, input logic [7:0] d);
    in_valid = v;
    inp      = d;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    inp       = 8'd200;
    out_ready = 1'b1;

    // Reset held three cycles with live input
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
    end
    rst_n = 1'b1;

    // Basic mean: (10+20+30+41)>>2 = 25
    send(1'b1, 8'd10);
    send(1'b1, 8'd20);
    send(1'b1, 8'd30);
    check("basic_not_early", 32'(out_valid), 32'd0);
    send(1'b1, 8'd41);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_mean", 32'(outp), 32'd25);
    send(1'b0, 8'd0);
    check("basic_one_cycle", 32'(out_valid), 32'd0);

    // Full-scale block, then a block with gaps between samples
    for (int i = 0; i < 4; i++) send(1'b1, 8'd255);
    check("max_mean", 32'(outp), 32'd255);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'd4);
      if (i < 3) check("gap_no_result", 32'(out_valid), 32'd0);
      if (i < 3) send(1'b0, 8'd99);
    end
    check("gap_mean", 32'(outp), 32'd4);
    send(1'b0, 8'd0);

    // Back-pressure: five blocks into a four-deep FIFO
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++)
      for (int i = 0; i < 4; i++) send(1'b1, 8'(b));
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_head", 32'(outp), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 8'd0);
    check("drain_empty", 32'(out_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Full FIFO with a pop on the completing edge
    rst_n = 1'b0;
    send(1'b0, 8'd0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int b = 5; b <= 8; b++)
      for (int i = 0; i < 4; i++) send(1'b1, 8'(b));
    for (int i = 0; i < 3; i++) send(1'b1, 8'd9);
    out_ready = 1'b1;
    send(1'b1, 8'd9);
    check("fullpop_overrun", 32'(overrun), 32'd0);
    check("fullpop_head", 32'(outp), 32'd6);
    for (int i = 0; i < 4; i++) send(1'b0, 8'd0);
    check("fullpop_empty", 32'(out_valid), 32'd0);

    // Reset in the middle of a block discards the partial sum
    send(1'b1, 8'd100);
    send(1'b1, 8'd100);
    rst_n = 1'b0;
    send(1'b1, 8'd100);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, 8'd8);
    check("midrst_mean", 32'(outp), 32'd8);
    check("midrst_overrun", 32'(overrun), 32'd0);
    send(1'b0, 8'd0);
    check("midrst_single", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sum_block_averager.md
# sum_block_averager

Downstream stage of the past-sequence adder. Consumes its running-sum stream and forms non-overlapping blocks of 2^M accepted samples. For each completed block it computes the truncated mean and queues the result in a small FIFO. The FIFO is drained through a valid/ready handshake toward the next consumer, and results that find no space are counted as overruns.

## Interface
- DW, 8, sample and result width; matches the adder's output width
- M, 2, log2 of block length (block = 2^M samples); M >= 1
- DEPTH, 4, result FIFO depth; power of two, >= 2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- in_valid  in  1  inp carries a sample this cycle; there is no back-pressure, so every in_valid sample is taken
- inp  in  DW  unsigned sample (the adder's outp)
- out_valid  out  1  FIFO non-empty; outp holds the head result
- out_ready  in  1  consumer accepts the head this cycle
- outp  out  DW  head-of-FIFO block mean; 0 when FIFO empty
- overrun  out  1  sticky; a completed block was dropped because the FIFO was full

## Operation
- Accumulator acc: DW+M bits, unsigned. It cannot overflow: the maximum is 2^M·(2^DW−1).
- Sample counter cnt: M bits, counts accepted samples in the current block.
- On an edge with in_valid=1:
  - if cnt < 2^M−1: acc <= acc+inp, cnt <= cnt+1
  - if cnt = 2^M−1 (last sample): result = (acc+inp) >> M, truncated, low DW bits. acc <= 0 and cnt <= 0 (wraps); push result.
- Edges with in_valid=0 leave acc and cnt unchanged. Gaps are allowed anywhere within a block.
- FIFO:
  - DEPTH entries, read and write pointers of log2(DEPTH)+1 bits.
  - full = pointers equal except MSB; empty = pointers equal.
  - pop = out_valid & out_ready.
  - push when full and no pop in the same cycle: result is discarded, FIFO is unchanged, overrun <= 1.
  - push and pop in the same cycle while full: both happen, no overrun, occupancy is unchanged.
  - push and pop in the same cycle while empty: impossible, since out_valid=0 and no pop occurs; the push lands normally.
- out_valid = !empty. outp = head entry when !empty, else 0. outp stays stable while out_valid=1 and out_ready=0.
- overrun clears only on reset.
- Reset, on an edge with rst_n=0 (takes priority over all other activity):
  - acc=0, cnt=0, FIFO emptied (pointers 0), overrun=0
  - hence out_valid=0 and outp=0 from the cycle after that edge
  - a partially accumulated block is discarded, and inputs on reset edges are ignored

## Timing
- Latency: the last sample of a block is accepted at edge t. The result is visible (out_valid=1, outp valid) in the cycle after edge t, provided the FIFO was empty.
- Throughput:
  - one sample per cycle
  - at most one push per 2^M cycles
  - one pop per cycle when out_ready is held high
- A pop at edge t presents the next entry, or out_valid=0, in the cycle after t.
- No combinational path from in_valid or inp to out_valid or outp.
- out_ready affects only FIFO state at the edge. There is no combinational path from out_ready to out_valid.
- All outputs are registered or derived from the FIFO registers only.

## Test plan
(DW=8, M=2, DEPTH=4)
- Reset: rst_n=0 for 3 cycles with in_valid=1, inp=200 -> out_valid=0, outp=0, overrun=0 throughout and after release; the first block starts fresh.
- Basic mean: out_ready=1, consecutive samples 10, 20, 30, 41 -> exactly one cycle of out_valid=1 with outp=25 (101>>2), in the cycle after the 4th sample.
- Max and gaps: samples 255×4, then 4, 4, 4, 4 with in_valid toggling 1,0,1,0,… -> outp=255, then outp=4 after the 8th accepted sample. No results are produced on gap cycles.
- Back-pressure and overrun:
  - out_ready=0, 5 blocks of constant 1, 2, 3, 4, 5 -> FIFO holds 1, 2, 3, 4; the 5th block is dropped and overrun=1.
  - then out_ready=1 -> outp 1, 2, 3, 4 on consecutive cycles, then out_valid=0; overrun stays 1.
- Full with simultaneous pop: FIFO full and out_ready=1 on the edge completing block value 9 -> head popped, 9 enqueued at tail, overrun stays 0.
- Reset mid-block: samples 100, 100, then rst_n=0 for one cycle, then 8, 8, 8, 8 -> single result outp=8. The partial block is discarded and overrun=0.
